// File: rtl/cbfp_block_scale_ctrl.sv
// rtl/cbfp_block_scale_ctrl.sv - CBFP block exponent controller: block-wide lane minimum, clamp, one-entry output
module cbfp_block_scale_ctrl #(
  parameter int MAG_WIDTH   = 5,
  parameter int LANES       = 16,
  parameter int BLOCK_BEATS = 4,
  parameter int MAX_SHIFT   = 22,
  parameter int ID_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAG_WIDTH-1:0]           mag_in [0:LANES-1],
  input  logic                           flush,
  output logic [$clog2(BLOCK_BEATS)-1:0] beat_idx,
  output logic                           exp_valid,
  input  logic                           exp_ready,
  output logic [MAG_WIDTH-1:0]           exp_out,
  output logic [ID_WIDTH-1:0]            exp_blk_id
);

  localparam int                   BI_W      = $clog2(BLOCK_BEATS);
  localparam logic [BI_W-1:0]      LAST_IDX  = BI_W'(BLOCK_BEATS - 1);
  localparam logic [MAG_WIDTH-1:0] SHIFT_CAP = MAG_WIDTH'(MAX_SHIFT);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t               state, state_nxt;
  logic [BI_W-1:0]      beat_idx_nxt;
  logic [MAG_WIDTH-1:0] beat_min;
  logic [MAG_WIDTH-1:0] run_min;
  logic [MAG_WIDTH-1:0] blk_min;
  logic [MAG_WIDTH-1:0] blk_exp;
  logic [ID_WIDTH-1:0]  blk_cnt;
  logic                 last_beat;
  logic                 accept;
  logic                 blk_done;

  // Unsigned minimum across all lanes of the presented beat
  always_comb begin
    beat_min = mag_in[0];
    for (int i = 1; i < LANES; i++) begin
      if (mag_in[i] < beat_min) beat_min = mag_in[i];
    end
  end

  // Only the closing beat of a block has to wait for the output slot to free up
  assign last_beat = (beat_idx == LAST_IDX);
  assign in_ready  = !flush && !(last_beat && exp_valid && !exp_ready);
  assign accept    = in_valid && in_ready;
  assign blk_done  = accept && last_beat;

  // Running minimum including the current beat, and its saturated exponent
  always_comb begin
    blk_min = run_min;
    if (state == S_IDLE || beat_min < run_min) blk_min = beat_min;
    blk_exp = (blk_min > SHIFT_CAP) ? SHIFT_CAP : blk_min;
  end

  // Accumulator state and beat index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_idx <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_idx_nxt;
    end
  end

  // Next-state: flush aborts a partial block, accepted beats advance the index
  always_comb begin
    state_nxt    = state;
    beat_idx_nxt = beat_idx;
    if (flush) begin
      state_nxt    = S_IDLE;
      beat_idx_nxt = '0;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          state_nxt    = S_ACCUM;
          beat_idx_nxt = BI_W'(1);
        end
        S_ACCUM: begin
          if (last_beat) begin
            state_nxt    = S_IDLE;
            beat_idx_nxt = '0;
          end else begin
            beat_idx_nxt = beat_idx + BI_W'(1);
          end
        end
        default: begin
          state_nxt    = S_IDLE;
          beat_idx_nxt = '0;
        end
      endcase
    end
  end

  // Running minimum register; a flush discards partial data
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      run_min <= '0;
    end else if (accept) begin
      run_min <= blk_min;
    end
  end

  // One-entry exponent slot; a new load in the handoff cycle keeps exp_valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_valid  <= 1'b0;
      exp_out    <= '0;
      exp_blk_id <= '0;
      blk_cnt    <= '0;
    end else if (blk_done) begin
      exp_valid  <= 1'b1;
      exp_out    <= blk_exp;
      exp_blk_id <= blk_cnt;
      blk_cnt    <= blk_cnt + ID_WIDTH'(1);
    end else if (exp_ready) begin
      exp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cbfp_block_scale_ctrl.sv
// tb/tb_cbfp_block_scale_ctrl.sv - scoreboard bench for cbfp_block_scale_ctrl
module tb_cbfp_block_scale_ctrl;

  localparam int MW = 5;
  localparam int LN = 16;
  localparam int BB = 4;
  localparam int MS = 22;
  localparam int IW = 8;
  localparam int NBLK = 260;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] mag [0:LN-1];
  logic          flush;
  logic [1:0]    beat_idx;
  logic          exp_valid;
  logic          exp_ready;
  logic [MW-1:0] exp_out;
  logic [IW-1:0] exp_blk_id;

  cbfp_block_scale_ctrl #(
    .MAG_WIDTH(MW), .LANES(LN), .BLOCK_BEATS(BB), .MAX_SHIFT(MS), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mag_in(mag),
    .flush(flush), .beat_idx(beat_idx), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_out(exp_out), .exp_blk_id(exp_blk_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int e;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mbeat = 0;
  int   mmin = 0;
  int   mid = 0;
  int   pushed = 0;
  int   popped = 0;
  int   last_pop_id = -1;
  bit   seen_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane_min();
    int m = 31;
    for (int i = 0; i < LN; i++) if (int'(mag[i]) < m) m = int'(mag[i]);
    return m;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < LN; i++) mag[i] = MW'(v);
  endtask

  // One clock: scoreboard handshake, model update, return at posedge+1
  task automatic cycle(output bit acc);
    exp_t e;
    int   bm;
    @(negedge clk);
    check("exp_valid", exp_valid, (sb.size() != 0));
    check("beat_idx", beat_idx, mbeat);
    check("in_ready", in_ready,
          !flush && !(mbeat == BB - 1 && sb.size() != 0 && !exp_ready));
    if (exp_valid && exp_ready) begin
      if (sb.size() == 0) begin
        check("sb_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_exp", exp_out, e.e);
        check("sb_id", exp_blk_id, e.id);
        if (last_pop_id == 255 && int'(exp_blk_id) == 0) seen_wrap = 1'b1;
        last_pop_id = int'(exp_blk_id);
        popped++;
      end
    end
    acc = in_valid && in_ready;
    if (flush) begin
      mbeat = 0;
    end else if (acc) begin
      bm = lane_min();
      if (mbeat == 0 || bm < mmin) mmin = bm;
      if (mbeat == BB - 1) begin
        e.id = mid;
        e.e  = (mmin > MS) ? MS : mmin;
        sb.push_back(e);
        mid = (mid + 1) % 256;
        mbeat = 0;
        pushed++;
      end else begin
        mbeat++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat();
    bit acc = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) cycle(acc);
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_block(input int v);
    fill(v);
    for (int b = 0; b < BB; b++) send_beat();
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    mbeat = 0;
    mid = 0;
  endtask

  bit acc;
  int cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; exp_ready = 1'b0;
    fill(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("rst_exp_valid", exp_valid, 0);
    check("rst_exp_out", exp_out, 0);
    check("rst_blk_id", exp_blk_id, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic block: lane 7 of beat 2 holds the minimum
    exp_ready = 1'b1;
    fill(10);
    send_beat(); send_beat();
    mag[7] = 5'd3;
    send_beat();
    fill(10);
    send_beat();
    in_valid = 1'b0;
    check("t1_valid", exp_valid, 1);
    check("t1_exp", exp_out, 3);
    check("t1_id", exp_blk_id, 0);
    cycle(acc);
    cycle(acc);

    // Backpressure: block A pending, block B stalls at its last beat
    exp_ready = 1'b0;
    send_block(5);
    fill(7);
    send_beat();
    mag[3] = 5'd4;
    send_beat();
    fill(7);
    send_beat();
    in_valid = 1'b1;
    cycle(acc);
    check("t2_stall0", acc, 0);
    cycle(acc);
    check("t2_stall1", acc, 0);
    check("t2_hold_exp", exp_out, 5);
    check("t2_hold_id", exp_blk_id, 1);
    exp_ready = 1'b1;
    cycle(acc);
    check("t2_accept", acc, 1);
    in_valid = 1'b0;
    check("t2_valid", exp_valid, 1);
    check("t2_exp", exp_out, 4);
    check("t2_id", exp_blk_id, 2);
    cycle(acc);

    // Clamp and zero
    send_block(31);
    check("t3_clamp", exp_out, 22);
    send_block(0);
    check("t3_zero", exp_out, 0);
    cycle(acc);

    // Flush after two beats
    fill(2);
    send_beat(); send_beat();
    flush = 1'b1;
    #1 check("t4_flush_ready", in_ready, 0);
    cycle(acc);
    check("t4_flush_acc", acc, 0);
    flush = 1'b0;
    send_block(9);
    check("t4_exp", exp_out, 9);
    check("t4_id", exp_blk_id, 5);
    cycle(acc);

    // Reset mid-block with an exponent pending
    exp_ready = 1'b0;
    send_block(6);
    fill(6);
    send_beat(); send_beat();
    in_valid = 1'b0;
    check("t5_pre_idx", beat_idx, 2);
    check("t5_pre_valid", exp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("t5_valid", exp_valid, 0);
    check("t5_idx", beat_idx, 0);
    exp_ready = 1'b1;
    send_block(12);
    check("t5_exp", exp_out, 12);
    check("t5_id", exp_blk_id, 0);
    cycle(acc);

    // Random traffic across the id wrap
    pushed = 0;
    popped = 0;
    cyc = 0;
    while ((pushed < NBLK || sb.size() != 0) && cyc < 20000) begin
      int base;
      in_valid  = (pushed < NBLK) && ($urandom_range(0, 9) < 7);
      exp_ready = (pushed >= NBLK) || ($urandom_range(0, 9) < 6);
      base = $urandom_range(0, 31);
      for (int i = 0; i < LN; i++) mag[i] = MW'(base + $urandom_range(0, 31 - base));
      cycle(acc);
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_timeout", (cyc < 20000), 1);
    check("rand_popped", popped, NBLK);
    check("rand_wrap", seen_wrap, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
